// File: rtl/shift_pkg.sv
// Shared types for the R-type shift execute stage: funct codes, occupancy states, buffer entry.
// SHIFT_VARIABLE_EN (optional define) enables sllv/srlv/srav support.
package shift_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int SHAMT_W     = $clog2(XLEN_DEF);

  typedef enum logic [5:0] {
    F_SLL  = 6'h00,
    F_SRL  = 6'h02,
    F_SRA  = 6'h03,
    F_SLLV = 6'h04,
    F_SRLV = 6'h06,
    F_SRAV = 6'h07
  } funct_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Buffer slot; sized by the package defaults, which the top-level parameters default to.
  typedef struct packed {
    logic [XLEN_DEF-1:0]    result;
    logic [RADDR_W_DEF-1:0] rd;
    logic                   illegal;
  } entry_t;

  function automatic logic is_variable(input logic [5:0] funct);
    return (funct == F_SLLV) || (funct == F_SRLV) || (funct == F_SRAV);
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: (funct, amount, value) -> (result, illegal).
// Variable-amount functs are only recognised when SHIFT_VARIABLE_EN is defined.
module shift_core
  import shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [XLEN-1:0]    value,
  output logic [XLEN-1:0]    result,
  output logic               illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (funct)
      F_SLL:   result = value << amount;
      F_SRL:   result = value >> amount;
      F_SRA:   result = $signed(value) >>> amount;
`ifdef SHIFT_VARIABLE_EN
      F_SLLV:  result = value << amount;
      F_SRLV:  result = value >> amount;
      F_SRAV:  result = $signed(value) >>> amount;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute stage for R-type shifts: shifter followed by a 2-entry in-order output buffer.
// SHIFT_VARIABLE_EN (optional define) enables sllv/srlv/srav; otherwise they are flagged illegal.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_funct,
  input  logic [4:0]         in_shamt,
  input  logic [XLEN-1:0]    in_rs_val,
  input  logic [XLEN-1:0]    in_rt_val,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_illegal
);

  occ_e             state_reg, state_next;
  logic             in_ready_reg;
  entry_t           slot_reg  [2];
  entry_t           slot_next [2];
  entry_t           new_entry;
  logic [SHAMT_W-1:0] amount;
  logic [XLEN-1:0]  core_result;
  logic             core_illegal;
  logic             in_xfer;
  logic             out_xfer;

`ifdef SHIFT_VARIABLE_EN
  logic unused_rs_hi;
  assign unused_rs_hi = ^in_rs_val[XLEN-1:SHAMT_W];
  assign amount = is_variable(in_funct) ? in_rs_val[SHAMT_W-1:0] : in_shamt;
`else
  logic unused_rs_all;
  assign unused_rs_all = ^in_rs_val;
  assign amount = in_shamt;
`endif

  shift_core #(.XLEN(XLEN)) u_core (
    .funct   (in_funct),
    .amount  (amount),
    .value   (in_rt_val),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign new_entry = '{result: core_result, rd: in_rd, illegal: core_illegal};

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (in_xfer) state_next = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_next = TWO;
        else if (out_xfer && !in_xfer) state_next = EMPTY;
      end
      TWO:     if (out_xfer) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Slot 0 is always the head; slot 1 only holds data in TWO and shifts down on a pop.
  always_comb begin
    slot_next[0] = slot_reg[0];
    slot_next[1] = slot_reg[1];
    case (state_reg)
      EMPTY: if (in_xfer) slot_next[0] = new_entry;
      ONE: begin
        if (in_xfer && out_xfer) slot_next[0] = new_entry;
        else if (in_xfer)        slot_next[1] = new_entry;
      end
      TWO: if (out_xfer) slot_next[0] = slot_reg[1];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
      for (int i = 0; i < 2; i++) slot_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
      for (int i = 0; i < 2; i++) slot_reg[i] <= slot_next[i];
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (state_reg != EMPTY);
  assign out_result  = slot_reg[0].result;
  assign out_rd      = slot_reg[0].rd;
  assign out_illegal = slot_reg[0].illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed cases plus randomized traffic against a queue model.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference shifter written from the instruction semantics with plain arithmetic.
  task automatic model_shift(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                             input logic [31:0] rt, output logic [31:0] r, output logic ill);
    int unsigned amt;
    bit          var_ok;
    logic [31:0] ones;
`ifdef SHIFT_VARIABLE_EN
    var_ok = 1'b1;
`else
    var_ok = 1'b0;
`endif
    ones = 32'hFFFF_FFFF;
    r    = 32'h0;
    ill  = 1'b0;
    amt  = 0;
    case (f)
      6'h00, 6'h02, 6'h03: amt = sh;
      6'h04, 6'h06, 6'h07: if (var_ok) amt = rs % 32; else ill = 1'b1;
      default:             ill = 1'b1;
    endcase
    if (!ill) begin
      case (f & 6'h03)
        6'h00:   r = rt * (32'd1 << amt);
        6'h02:   r = rt / (32'd1 << amt);
        default: r = (rt >> amt) | (rt[31] ? ~(ones >> amt) : 32'h0);
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, q.size() > 0});
    check({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, q.size() < 2});
    if (q.size() > 0) begin
      check({tag, "_result"}, out_result, q[0].res);
      check({tag, "_rd"}, {27'b0, out_rd}, {27'b0, q[0].rd});
      check({tag, "_illegal"}, {31'b0, out_illegal}, {31'b0, q[0].ill});
    end
  endtask

  // One clock: drive inputs, predict transfers from pre-edge values, update model, check.
  task automatic drive(input string tag, input logic v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                       input logic ordy);
    exp_t e;
    bit   in_x;
    bit   out_x;
    in_valid  = v;
    in_funct  = f;
    in_shamt  = sh;
    in_rs_val = rs;
    in_rt_val = rt;
    in_rd     = rd;
    out_ready = ordy;
    #1;
    in_x  = v && in_ready;
    out_x = out_valid && ordy;
    model_shift(f, sh, rs, rt, e.res, e.ill);
    e.rd = rd;
    @(posedge clk);
    #1;
    if (out_x && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    if (in_x) q.push_back(e);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    drive(tag, 1'b0, 6'h00, 5'd0, 32'h0, 32'h0, 5'd0, ordy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_funct = '0; in_shamt = '0;
    in_rs_val = '0; in_rt_val = '0; in_rd = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_result", out_result, 32'd0);
    check("rst_rd", {27'b0, out_rd}, 32'd0);
    check("rst_illegal", {31'b0, out_illegal}, 32'd0);
    rst = 1'b0;

    drive("sll", 1'b1, 6'h00, 5'd1, 32'h0, 32'h0000_002D, 5'd1, 1'b1);
    check("sll_value", out_result, 32'h0000_005A);
    check("sll_legal", {31'b0, out_illegal}, 32'd0);
    drive("sra", 1'b1, 6'h03, 5'd4, 32'h0, 32'h8000_0000, 5'd2, 1'b1);
    check("sra_value", out_result, 32'hF800_0000);
    drive("srl", 1'b1, 6'h02, 5'd4, 32'h0, 32'h8000_0000, 5'd3, 1'b1);
    check("srl_value", out_result, 32'h0800_0000);
    drive("sllv", 1'b1, 6'h04, 5'd0, 32'h0000_0023, 32'h1, 5'd4, 1'b1);
`ifdef SHIFT_VARIABLE_EN
    check("sllv_value", out_result, 32'h0000_0008);
    check("sllv_illegal", {31'b0, out_illegal}, 32'd0);
`else
    check("sllv_value", out_result, 32'h0);
    check("sllv_illegal", {31'b0, out_illegal}, 32'd1);
`endif
    idle("drain1", 1'b1);

    drive("bp1", 1'b1, 6'h00, 5'd2, 32'h0, 32'h11, 5'd1, 1'b0);
    drive("bp2", 1'b1, 6'h00, 5'd2, 32'h0, 32'h22, 5'd2, 1'b0);
    check("bp_full_ready", {31'b0, in_ready}, 32'd0);
    drive("bp3", 1'b1, 6'h00, 5'd2, 32'h0, 32'h33, 5'd3, 1'b0);
    check("bp_hold_rd", {27'b0, out_rd}, 32'd1);
    drive("bp4", 1'b1, 6'h00, 5'd2, 32'h0, 32'h33, 5'd3, 1'b1);
    check("bp_second_rd", {27'b0, out_rd}, 32'd2);
    drive("bp5", 1'b1, 6'h00, 5'd2, 32'h0, 32'h33, 5'd3, 1'b1);
    check("bp_third_rd", {27'b0, out_rd}, 32'd3);
    idle("drain2", 1'b1);

    pops = 0;
    for (int i = 0; i < 8; i++)
      drive("stream", 1'b1, 6'h02, 5'(i), 32'h0, $urandom, 5'(i + 8), 1'b1);
    idle("stream_end", 1'b1);
    check("stream_count", pops, 32'd8);

    drive("illegal", 1'b1, 6'h20, 5'd3, 32'h5, 32'hFFFF_FFFF, 5'd9, 1'b1);
    check("illegal_result", out_result, 32'h0);
    check("illegal_flag", {31'b0, out_illegal}, 32'd1);
    idle("drain3", 1'b1);
    drive("fill1", 1'b1, 6'h00, 5'd1, 32'h0, 32'h7, 5'd10, 1'b0);
    drive("fill2", 1'b1, 6'h00, 5'd1, 32'h0, 32'h8, 5'd11, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    idle("post_rst", 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      case ($urandom_range(0, 7))
        0: f = 6'h00;
        1: f = 6'h02;
        2: f = 6'h03;
        3: f = 6'h04;
        4: f = 6'h06;
        5: f = 6'h07;
        6: f = 6'h20;
        default: f = 6'($urandom);
      endcase
      drive("rand", 1'($urandom_range(0, 3) != 0), f, 5'($urandom), $urandom, $urandom,
            5'($urandom), 1'($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 3; i++) idle("final", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
